argmax_classifier: RTL and testbench

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

---
 rtl/argmax_classifier.sv | 159 +++++++++++++++
 tb/tb_argmax_classifier.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module   : argmax_classifier
// Purpose  : Sequences NUM_ROWS multiplier row scores and reports the
//            highest-scoring row (lowest index wins ties).
//            Optional macro ARGMAX_TIMEOUT_EN adds a WAIT-state watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module argmax_classifier #(
  parameter int NUM_ROWS       = 10,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        done_row,
  input  logic [15:0] row_result,
  output logic        begin_mult,
  output logic [3:0]  row_select,
  output logic        busy,
  output logic        result_valid,
  output logic [3:0]  digit,
  output logic [15:0] max_score,
  output logic        timeout_err
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [3:0] c_LAST_ROW = 4'(NUM_ROWS - 1);

  if (NUM_ROWS < 2 || NUM_ROWS > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("argmax_classifier: NUM_ROWS must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]         r_state;
  logic [3:0]         r_row;
  logic [3:0]         r_digit;
  logic signed [15:0] r_max;
  logic               w_take;

  // Row 0 always seeds the running maximum; later rows need a strict win.
  assign w_take = (r_row == 4'd0) || ($signed(row_result) > r_max);

`ifdef ARGMAX_TIMEOUT_EN
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(TIMEOUT_CYCLES - 1);

  logic [c_TW-1:0] r_timer;
  logic            r_timeout;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= c_IDLE;
      r_row     <= 4'd0;
      r_digit   <= 4'd0;
      r_max     <= 16'sd0;
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_state   <= c_ISSUE;
            r_row     <= 4'd0;
            r_timeout <= 1'b0;
          end
        end
        c_ISSUE: begin
          r_state <= c_WAIT;
          r_timer <= '0;
        end
        c_WAIT: begin
          if (done_row) begin
            if (w_take) begin
              r_max   <= $signed(row_result);
              r_digit <= r_row;
            end
            if (r_row == c_LAST_ROW) begin
              r_state <= c_DONE;
            end else begin
              r_row   <= r_row + 4'd1;
              r_state <= c_ISSUE;
            end
          end else if (r_timer == c_TIMER_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= c_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign timeout_err = r_timeout;
`else
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= c_IDLE;
      r_row   <= 4'd0;
      r_digit <= 4'd0;
      r_max   <= 16'sd0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_state <= c_ISSUE;
            r_row   <= 4'd0;
          end
        end
        c_ISSUE: begin
          r_state <= c_WAIT;
        end
        c_WAIT: begin
          if (done_row) begin
            if (w_take) begin
              r_max   <= $signed(row_result);
              r_digit <= r_row;
            end
            if (r_row == c_LAST_ROW) begin
              r_state <= c_DONE;
            end else begin
              r_row   <= r_row + 4'd1;
              r_state <= c_ISSUE;
            end
          end
        end
        c_DONE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign timeout_err = 1'b0;
`endif

  // Outputs decode the registered state, so reset clears them immediately.
  assign begin_mult   = (r_state == c_ISSUE);
  assign busy         = (r_state != c_IDLE);
  assign result_valid = (r_state == c_DONE);
  assign row_select   = r_row;
  assign digit        = r_digit;
  assign max_score    = r_max;

endmodule
`default_nettype wire

// File: tb/tb_argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module   : tb_argmax_classifier
// Purpose  : Self-checking bench for argmax_classifier with a latency-L
//            multiplier model and an argmax reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_argmax_classifier;

  localparam int NUM_ROWS = 10;
`ifdef ARGMAX_TIMEOUT_EN
  localparam int TIMEOUT_CYCLES = 16;
`else
  localparam int TIMEOUT_CYCLES = 2048;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic        done_row = 1'b0;
  logic [15:0] row_result = 16'd0;
  logic        begin_mult;
  logic [3:0]  row_select;
  logic        busy;
  logic        result_valid;
  logic [3:0]  digit;
  logic [15:0] max_score;
  logic        timeout_err;

  int tests = 0;
  int fails = 0;

  int  mult_lat = 4;
  int  mult_cnt = 0;
  int  pend_row = 0;
  int  withhold_row = -1;
  bit  inject_stray = 1'b0;
  int  begin_cnt = 0;
  int  rv_cnt = 0;
  int  rows_q[$];
  logic signed [15:0] scores [NUM_ROWS];

  argmax_classifier #(
    .NUM_ROWS       (NUM_ROWS),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .done_row     (done_row),
    .row_result   (row_result),
    .begin_mult   (begin_mult),
    .row_select   (row_select),
    .busy         (busy),
    .result_valid (result_valid),
    .digit        (digit),
    .max_score    (max_score),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  // Multiplier model: done_row arrives L idle cycles after the begin_mult cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      done_row = 1'b0;
      if (!n_rst) begin
        mult_cnt = 0;
      end else begin
        if (mult_cnt > 0) begin
          mult_cnt--;
          if (mult_cnt == 0) begin
            done_row   = 1'b1;
            row_result = scores[pend_row];
          end
        end
        if (begin_mult === 1'b1) begin
          begin_cnt++;
          rows_q.push_back(int'(row_select));
          if (inject_stray) begin
            done_row   = 1'b1;
            row_result = 16'h7fff;
          end
          if (int'(row_select) != withhold_row) begin
            mult_cnt = mult_lat + 1;
            pend_row = int'(row_select);
          end
        end
        if (result_valid === 1'b1) rv_cnt++;
      end
    end
  end

  // Reference: find the largest value, then the first row holding it.
  task automatic ref_argmax(output logic [3:0] d, output logic [15:0] m);
    logic signed [15:0] best;
    best = scores[0];
    foreach (scores[i]) if (scores[i] > best) best = scores[i];
    d = 4'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) if (scores[i] == best) d = 4'(i);
    m = best;
  endtask

  task automatic run_class(output int cycles);
    begin_cnt = 0;
    rv_cnt = 0;
    rows_q.delete();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    cycles = 1;
    while (result_valid !== 1'b1 && cycles < 3000) begin
      @(posedge clk); #2;
      cycles++;
    end
    repeat (3) begin @(posedge clk); #2; end
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (begin_mult !== 1'b0) begin fails++; $display("FAIL reset_begin_mult: got %b want 0", begin_mult); end
    tests++; if (row_select !== 4'd0) begin fails++; $display("FAIL reset_row_select: got %0d want 0", row_select); end
    tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_result_valid: got %b want 0", result_valid); end
    tests++; if (digit !== 4'd0) begin fails++; $display("FAIL reset_digit: got %0d want 0", digit); end
    tests++; if (max_score !== 16'd0) begin fails++; $display("FAIL reset_max_score: got %h want 0000", max_score); end
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout_err: got %b want 0", timeout_err); end
    n_rst = 1'b1;
    repeat (2) begin @(posedge clk); #2; end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_after_release: busy got %b want 0", busy); end
  endtask

  task automatic test_spec_vector;
    int cyc;
    int vals [NUM_ROWS] = '{5, 90, -3, 12, 90, 7, 0, 1, 2, 3};
    foreach (vals[i]) scores[i] = 16'(vals[i]);
    mult_lat = 4;
    run_class(cyc);
    tests++; if (digit !== 4'd1) begin fails++; $display("FAIL spec_digit: got %0d want 1", digit); end
    tests++; if (max_score !== 16'd90) begin fails++; $display("FAIL spec_max: got %0d want 90", $signed(max_score)); end
    tests++; if (cyc != 61) begin fails++; $display("FAIL spec_latency: got %0d want 61", cyc); end
    tests++; if (rv_cnt != 1) begin fails++; $display("FAIL spec_rv_count: got %0d want 1", rv_cnt); end
    tests++; if (begin_cnt != NUM_ROWS) begin fails++; $display("FAIL spec_begin_count: got %0d want %0d", begin_cnt, NUM_ROWS); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL spec_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_negative;
    int cyc;
    for (int i = 0; i < NUM_ROWS; i++) scores[i] = 16'(-100 + i);
    mult_lat = 2;
    run_class(cyc);
    tests++; if (digit !== 4'd9) begin fails++; $display("FAIL neg_digit: got %0d want 9", digit); end
    tests++; if (max_score !== 16'(-91)) begin fails++; $display("FAIL neg_max: got %0d want -91", $signed(max_score)); end
    tests++; if (cyc != NUM_ROWS * 4 + 1) begin fails++; $display("FAIL neg_latency: got %0d want %0d", cyc, NUM_ROWS * 4 + 1); end
  endtask

  task automatic test_random;
    int cyc;
    logic [3:0]  ed;
    logic [15:0] em;
    for (int it = 0; it < 8; it++) begin
      foreach (scores[i]) scores[i] = 16'($urandom);
      if (it % 2 == 1) begin
        ref_argmax(ed, em);
        scores[$urandom_range(int'(ed), NUM_ROWS - 1)] = em;
      end
      if (it == 2) scores[NUM_ROWS - 1] = 16'h7fff;
      if (it == 4) scores[0] = 16'h7fff;
      mult_lat = $urandom_range(1, 6);
      ref_argmax(ed, em);
      run_class(cyc);
      tests++; if (digit !== ed) begin fails++; $display("FAIL rand_digit[%0d]: got %0d want %0d", it, digit, ed); end
      tests++; if (max_score !== em) begin fails++; $display("FAIL rand_max[%0d]: got %0d want %0d", it, $signed(max_score), $signed(em)); end
      tests++; if (cyc != NUM_ROWS * (2 + mult_lat) + 1) begin
        fails++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, cyc, NUM_ROWS * (2 + mult_lat) + 1);
      end
    end
  endtask

  task automatic test_ignore;
    int cyc;
    bit seq_ok;
    logic [3:0]  ed;
    logic [15:0] em;
    foreach (scores[i]) scores[i] = 16'($urandom_range(0, 2000));
    mult_lat = 4;
    inject_stray = 1'b1;
    ref_argmax(ed, em);
    fork
      run_class(cyc);
      begin
        repeat (4) @(posedge clk);
        #3 start = 1'b1;
        @(posedge clk);
        #3 start = 1'b0;
      end
    join
    inject_stray = 1'b0;
    seq_ok = (rows_q.size() == NUM_ROWS);
    for (int i = 0; i < rows_q.size(); i++) if (rows_q[i] != i) seq_ok = 1'b0;
    tests++; if (begin_cnt != NUM_ROWS) begin fails++; $display("FAIL ign_begin_count: got %0d want %0d", begin_cnt, NUM_ROWS); end
    tests++; if (!seq_ok) begin fails++; $display("FAIL ign_row_sequence: got %p want 0..%0d", rows_q, NUM_ROWS - 1); end
    tests++; if (rv_cnt != 1) begin fails++; $display("FAIL ign_rv_count: got %0d want 1", rv_cnt); end
    tests++; if (digit !== ed || max_score !== em) begin
      fails++; $display("FAIL ign_result: got %0d/%0d want %0d/%0d", digit, $signed(max_score), ed, $signed(em));
    end
    tests++; if (cyc != NUM_ROWS * 6 + 1) begin fails++; $display("FAIL ign_latency: got %0d want %0d", cyc, NUM_ROWS * 6 + 1); end
    repeat (3) begin @(posedge clk); #2; end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ign_no_restart: busy got %b want 0", busy); end
  endtask

  task automatic test_hold;
    logic [3:0]  ed;
    logic [15:0] em;
    ref_argmax(ed, em);
    repeat (4) begin @(posedge clk); #2; end
    done_row = 1'b1;
    row_result = 16'h7fff;
    repeat (3) begin @(posedge clk); #2; end
    tests++; if (digit !== ed || max_score !== em || busy !== 1'b0) begin
      fails++; $display("FAIL idle_hold: got %0d/%0d busy %b want %0d/%0d busy 0", digit, $signed(max_score), busy, ed, $signed(em));
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    int guard;
    logic [3:0]  ed;
    logic [15:0] em;
    foreach (scores[i]) scores[i] = 16'($urandom);
    scores[0] = 16'd1000;
    mult_lat = 4;
    begin_cnt = 0;
    rv_cnt = 0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    guard = 0;
    while (begin_cnt < 5 && guard < 500) begin @(posedge clk); #2; guard++; end
    tests++; if (begin_cnt != 5) begin fails++; $display("FAIL rmid_reach_row4: begin count %0d want 5", begin_cnt); end
    repeat (2) begin @(posedge clk); #2; end
    n_rst = 1'b0;
    #1;
    tests++; if ({busy, begin_mult, row_select, result_valid, digit, max_score, timeout_err} !== 28'd0) begin
      fails++; $display("FAIL rmid_outputs_zero: busy %b bm %b row %0d rv %b digit %0d max %h to %b want all 0",
                        busy, begin_mult, row_select, result_valid, digit, max_score, timeout_err);
    end
    repeat (3) @(posedge clk);
    #2 n_rst = 1'b1;
    repeat (6) begin @(posedge clk); #2; end
    tests++; if (rv_cnt != 0 || busy !== 1'b0) begin fails++; $display("FAIL rmid_abandon: rv %0d busy %b want 0 0", rv_cnt, busy); end
    ref_argmax(ed, em);
    run_class(cyc);
    tests++; if (begin_cnt != NUM_ROWS || rows_q[0] != 0) begin
      fails++; $display("FAIL rmid_rerun_rows: begins %0d first %0d want %0d 0", begin_cnt, rows_q[0], NUM_ROWS);
    end
    tests++; if (digit !== ed || max_score !== em) begin
      fails++; $display("FAIL rmid_rerun_result: got %0d/%0d want %0d/%0d", digit, $signed(max_score), ed, $signed(em));
    end
  endtask

  task automatic test_timeout;
    int cyc;
    int guard;
    logic [3:0]  ed;
    logic [15:0] em;
    foreach (scores[i]) scores[i] = 16'($urandom);
    mult_lat = 4;
    withhold_row = 2;
    begin_cnt = 0;
    rv_cnt = 0;
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
`ifdef ARGMAX_TIMEOUT_EN
    cyc = 1;
    while (busy !== 1'b0 && cyc < 500) begin @(posedge clk); #2; cyc++; end
    tests++; if (cyc != 2 * (2 + mult_lat) + 1 + TIMEOUT_CYCLES + 1) begin
      fails++; $display("FAIL to_abort_cycle: got %0d want %0d", cyc, 2 * (2 + mult_lat) + 1 + TIMEOUT_CYCLES + 1);
    end
    tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_flag_set: got %b want 1", timeout_err); end
    tests++; if (rv_cnt != 0 || begin_cnt != 3) begin fails++; $display("FAIL to_no_result: rv %0d begins %0d want 0 3", rv_cnt, begin_cnt); end
    repeat (3) begin @(posedge clk); #2; end
    tests++; if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_flag_sticky: got %b want 1", timeout_err); end
    withhold_row = -1;
    ref_argmax(ed, em);
    run_class(cyc);
    tests++; if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_flag_cleared: got %b want 0", timeout_err); end
    tests++; if (digit !== ed || max_score !== em) begin
      fails++; $display("FAIL to_rerun_result: got %0d/%0d want %0d/%0d", digit, $signed(max_score), ed, $signed(em));
    end
`else
    guard = 0;
    repeat (300) begin @(posedge clk); #2; guard++; end
    tests++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin
      fails++; $display("FAIL wait_forever: busy %b to %b after %0d cycles want 1 0", busy, timeout_err, guard);
    end
    tests++; if (row_select !== 4'd2 || rv_cnt != 0) begin fails++; $display("FAIL wait_row: row %0d rv %0d want 2 0", row_select, rv_cnt); end
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 n_rst = 1'b1;
    withhold_row = -1;
    ref_argmax(ed, em);
    run_class(cyc);
    tests++; if (digit !== ed || max_score !== em || timeout_err !== 1'b0) begin
      fails++; $display("FAIL wait_rerun: got %0d/%0d to %b want %0d/%0d 0", digit, $signed(max_score), timeout_err, ed, $signed(em));
    end
`endif
  endtask

  initial begin
    foreach (scores[i]) scores[i] = 16'sd0;
    test_reset();
    test_spec_vector();
    test_negative();
    test_random();
    test_ignore();
    test_hold();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
